alu_flag_commit: RTL and testbench
==================================

// Module: alu_flag_commit
// PURPOSE
//  Commit stage at the ALU output. Consumes result + status_reg, keeps the architectural
//  flag register {Z,N,C,V} and resolves conditional branches against it.
//  Buffers write-back entries for the register file in a small FIFO with valid/ready.
//  Sits between the ALU and the register-file write port / PC-select logic.
// PARAMETERS
//  DATA_W   16  width of ALU result and branch target
//  RD_W     3   destination register index width
//  DEPTH    2   write-back FIFO entries (power of two, >=2)
// PORTS
//  clk           in   1       rising-edge clock
//  rst_n         in   1       synchronous reset, active low
//  in_valid      in   1       upstream op present
//  in_ready      out  1       op accepted when in_valid & in_ready at clk edge
//  in_result     in   DATA_W  ALU result
//  in_status     in   16      ALU status: [15]=Z [14]=N [13]=C [12]=V, [11:0] ignored
//  in_rd         in   RD_W    destination register
//  in_wr_en      in   1       op writes in_result to in_rd
//  in_flag_we    in   1       op updates flag register
//  in_br_en      in   1       op is a branch
//  in_br_cond    in   3       branch condition code (see BEHAVIOUR)
//  in_br_target  in   DATA_W  branch target address
//  out_valid     out  1       FIFO head valid
//  out_ready     in   1       register file takes head
//  out_data      out  DATA_W  head result
//  out_rd        out  RD_W    head destination
//  flags         out  4       architectural flags {Z,N,C,V}
//  br_taken      out  1       one-cycle pulse: branch resolved taken
//  br_target     out  DATA_W  target, valid while br_taken=1
// BEHAVIOUR
//  Reset (rst_n=0 at edge): FIFO count=0, out_valid=0, out_data=0, out_rd=0, flags=0,
//   br_taken=0, br_target=0; in_ready=0 while rst_n=0. In-flight entries are dropped.
//  in_ready = rst_n & (count < DEPTH); derived from registered count only, with no
//   combinational path from out_ready.
//  Accept (in_valid&in_ready): if in_wr_en, push {in_result,in_rd}; ops with in_wr_en=0
//   do not occupy the FIFO. Pushed entry is visible at out_* on the next cycle (latency 1).
//  Pop on out_valid&out_ready. Push and pop in the same cycle leave count unchanged.
//   Order is strict FIFO. Pointers wrap modulo DEPTH.
//  Flags: on accept with in_flag_we=1, flags <= in_status[15:12] at that edge;
//   otherwise flags hold.
//  Branch: on accept with in_br_en=1, evaluate in_br_cond against flags BEFORE this
//   op's own flag update. Conditions:
//   000 always; 001 EQ (Z); 010 NE (!Z); 011 LT (N^V); 100 GE (!(N^V));
//   101 CS (C); 110 VS (V); 111 never.
//  Taken: br_taken=1 and br_target=in_br_target for exactly the next cycle, then
//   br_taken returns to 0 (br_target holds).
//   Not-taken, or no branch: br_taken=0.
//  An op may combine wr_en, flag_we and br_en; each side effect is applied independently.
//  in_valid with in_ready=0: nothing happens; flags, branch and FIFO are all untouched.
// TESTING
//  1 rst_n=0 for 2 cycles with in_valid=1, in_wr_en=1 -> in_ready=0, out_valid=0,
//    flags=0, br_taken=0; after release in_ready=1.
//  2 op status=16'h8000 flag_we=1, then op status=16'h4000 flag_we=0 -> flags=4'b1000
//    after the first edge and still 4'b1000 after the second.
//  3 flags=4'b0100, branch cond=011 target=16'h0040 -> br_taken=1 for one cycle,
//    br_target=16'h0040. Then cond=100 -> br_taken=0.
//  4 Same-op check: flags=0, op flag_we=1 status=16'h8000 br_en=1 cond=001 -> not taken,
//    flags=4'b1000 afterwards.
//  5 out_ready=0, push 0x0011, 0x0022, 0x0033 -> in_ready=0 after 2 pushes. Raise out_ready
//    -> out 0x0011, then 0x0022; 0x0033 is accepted after the first pop and comes out third.
//  6 out_ready=1, stream 8 pushes back to back -> 8 pops, one per cycle, in order,
//    count never exceeds 1. Then fill to 2 and pulse rst_n=0 -> out_valid=0, flags=0.

Source files
------------

// File: rtl/alu_flag_commit.sv
// rtl/alu_flag_commit.sv - ALU commit stage: flag register, branch resolve, write-back FIFO
module alu_flag_commit #(
   parameter int DATA_W = 16,
   parameter int RD_W   = 3,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic [15:0]       in_status,
   input  logic [RD_W-1:0]   in_rd,
   input  logic              in_wr_en,
   input  logic              in_flag_we,
   input  logic              in_br_en,
   input  logic [2:0]        in_br_cond,
   input  logic [DATA_W-1:0] in_br_target,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [RD_W-1:0]   out_rd,
   output logic [3:0]        flags,
   output logic              br_taken,
   output logic [DATA_W-1:0] br_target
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

   logic [DATA_W-1:0] r_mem_data [DEPTH];
   logic [RD_W-1:0]   r_mem_rd   [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [3:0]        r_flags;
   logic              r_br_taken;
   logic [DATA_W-1:0] r_br_target;

   logic w_accept;
   logic w_push;
   logic w_pop;
   logic w_cond_met;
   logic w_unused_status;

   assign w_unused_status = ^in_status[11:0];

   // in_ready depends only on registered occupancy, never on out_ready
   assign in_ready  = rst_n & (r_count < C_DEPTH);
   assign out_valid = (r_count != '0);
   assign w_accept  = in_valid & in_ready;
   assign w_push    = w_accept & in_wr_en;
   assign w_pop     = out_valid & out_ready;

   assign out_data  = r_mem_data[r_rd_ptr];
   assign out_rd    = r_mem_rd[r_rd_ptr];
   assign flags     = r_flags;
   assign br_taken  = r_br_taken;
   assign br_target = r_br_target;

   // Conditions read the flags held before this op's own flag update
   always_comb begin
      w_cond_met = 1'b0;
      case (in_br_cond)
         3'b000: w_cond_met = 1'b1;
         3'b001: w_cond_met = r_flags[3];
         3'b010: w_cond_met = ~r_flags[3];
         3'b011: w_cond_met = r_flags[2] ^ r_flags[0];
         3'b100: w_cond_met = ~(r_flags[2] ^ r_flags[0]);
         3'b101: w_cond_met = r_flags[1];
         3'b110: w_cond_met = r_flags[0];
         default: w_cond_met = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_data[i] <= '0;
            r_mem_rd[i]   <= '0;
         end
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_flags     <= '0;
         r_br_taken  <= 1'b0;
         r_br_target <= '0;
      end else begin
         if (w_push) begin
            r_mem_data[r_wr_ptr] <= in_result;
            r_mem_rd[r_wr_ptr]   <= in_rd;
            r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         if (w_accept && in_flag_we) begin
            r_flags <= in_status[15:12];
         end
         r_br_taken <= w_accept & in_br_en & w_cond_met;
         if (w_accept && in_br_en && w_cond_met) begin
            r_br_target <= in_br_target;
         end
      end
   end
endmodule

// File: tb/tb_alu_flag_commit.sv
// tb/tb_alu_flag_commit.sv - directed and randomized checks against a queue-based model
module tb_alu_flag_commit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_result;
   logic [15:0] in_status;
   logic [2:0]  in_rd;
   logic        in_wr_en;
   logic        in_flag_we;
   logic        in_br_en;
   logic [2:0]  in_br_cond;
   logic [15:0] in_br_target;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [2:0]  out_rd;
   logic [3:0]  flags;
   logic        br_taken;
   logic [15:0] br_target;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   logic [18:0] m_q[$];
   logic [3:0]  m_flags;
   logic        m_br;
   logic [15:0] m_tgt;

   alu_flag_commit dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_status(in_status), .in_rd(in_rd),
      .in_wr_en(in_wr_en), .in_flag_we(in_flag_we), .in_br_en(in_br_en),
      .in_br_cond(in_br_cond), .in_br_target(in_br_target),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_rd(out_rd), .flags(flags), .br_taken(br_taken), .br_target(br_target)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit cond_true(input logic [2:0] c, input logic [3:0] f);
      bit z, n, cy, v;
      {z, n, cy, v} = f;
      case (c)
         3'd0: return 1'b1;
         3'd1: return z;
         3'd2: return !z;
         3'd3: return n != v;
         3'd4: return n == v;
         3'd5: return cy;
         3'd6: return v;
         default: return 1'b0;
      endcase
   endfunction

   always @(posedge clk) begin
      bit acc, taken;
      if (!rst_n) begin
         m_q.delete();
         m_flags = 4'd0;
         m_br    = 1'b0;
         m_tgt   = 16'd0;
      end else begin
         acc   = in_valid && (m_q.size() < 2);
         taken = acc && in_br_en && cond_true(in_br_cond, m_flags);
         if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
         if (acc && in_wr_en) m_q.push_back({in_result, in_rd});
         if (acc && in_flag_we) m_flags = in_status[15:12];
         m_br = taken;
         if (taken) m_tgt = in_br_target;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", in_ready, rst_n && (m_q.size() < 2));
         chk("out_valid", out_valid, m_q.size() != 0);
         if (m_q.size() != 0) begin
            chk("out_data", out_data, m_q[0][18:3]);
            chk("out_rd", out_rd, m_q[0][2:0]);
         end
         chk("flags", flags, m_flags);
         chk("br_taken", br_taken, m_br);
         if (m_br) chk("br_target", br_target, m_tgt);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 0; in_wr_en = 0; in_flag_we = 0; in_br_en = 0;
      in_result = 0; in_status = 0; in_rd = 0; in_br_cond = 0; in_br_target = 0;
   endtask

   task automatic op(input bit wr, input logic [15:0] res, input logic [2:0] rd,
                     input bit fwe, input logic [15:0] st,
                     input bit br, input logic [2:0] c, input logic [15:0] tgt);
      in_valid = 1; in_wr_en = wr; in_result = res; in_rd = rd;
      in_flag_we = fwe; in_status = st; in_br_en = br; in_br_cond = c; in_br_target = tgt;
   endtask

   initial begin
      idle();
      rst_n = 0; out_ready = 0;
      in_valid = 1; in_wr_en = 1; in_result = 16'hbeef;
      #1;
      chk("rst_in_ready_comb", in_ready, 1'b0);
      tick();
      chk_en = 1'b1;
      tick();
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_flags", flags, 4'd0);
      chk("rst_br_taken", br_taken, 1'b0);
      chk("rst_out_data", out_data, 16'd0);
      chk("rst_br_target", br_target, 16'd0);
      idle();
      rst_n = 1;
      #1;
      chk("release_in_ready", in_ready, 1'b1);

      op(0, 0, 0, 1, 16'h8000, 0, 0, 0); tick();
      chk("flag_set", flags, 4'b1000);
      op(0, 0, 0, 0, 16'h4000, 0, 0, 0); tick();
      chk("flag_hold", flags, 4'b1000);

      op(0, 0, 0, 1, 16'h4000, 0, 0, 0); tick();
      chk("flag_n", flags, 4'b0100);
      op(0, 0, 0, 0, 0, 1, 3'b011, 16'h0040); tick();
      chk("lt_taken", br_taken, 1'b1);
      chk("lt_target", br_target, 16'h0040);
      idle(); tick();
      chk("lt_pulse_end", br_taken, 1'b0);
      chk("lt_target_hold", br_target, 16'h0040);
      op(0, 0, 0, 0, 0, 1, 3'b100, 16'h0080); tick();
      chk("ge_not_taken", br_taken, 1'b0);

      op(0, 0, 0, 1, 16'h0000, 0, 0, 0); tick();
      op(0, 0, 0, 1, 16'h8000, 1, 3'b001, 16'h0100); tick();
      chk("same_op_not_taken", br_taken, 1'b0);
      chk("same_op_flags", flags, 4'b1000);

      out_ready = 0;
      op(1, 16'h0011, 3'd1, 0, 0, 0, 0, 0); tick();
      op(1, 16'h0022, 3'd2, 0, 0, 0, 0, 0); tick();
      chk("full_in_ready", in_ready, 1'b0);
      op(1, 16'h0033, 3'd3, 0, 0, 0, 0, 0); tick();
      chk("full_hold_ready", in_ready, 1'b0);
      chk("head_11", out_data, 16'h0011);
      out_ready = 1; tick();
      chk("pop1_22", out_data, 16'h0022);
      chk("pop1_ready", in_ready, 1'b1);
      tick();
      idle();
      chk("third_33", out_data, 16'h0033);
      chk("third_rd", out_rd, 3'd3);
      tick();
      chk("drained", out_valid, 1'b0);

      for (int i = 0; i < 8; i++) begin
         op(1, 16'h0100 + 16'(i), 3'(i), 0, 0, 0, 0, 0);
         tick();
         chk("stream_data", out_data, 16'h0100 + 16'(i));
         chk("stream_ready", in_ready, 1'b1);
      end
      idle(); tick();
      chk("stream_empty", out_valid, 1'b0);

      out_ready = 0;
      op(1, 16'h0a0a, 3'd5, 1, 16'hf000, 0, 0, 0); tick();
      op(1, 16'h0b0b, 3'd6, 0, 0, 0, 0, 0); tick();
      idle();
      chk("fill_ready", in_ready, 1'b0);
      chk("fill_flags", flags, 4'hf);
      rst_n = 0; tick();
      chk("rst2_out_valid", out_valid, 1'b0);
      chk("rst2_flags", flags, 4'd0);
      rst_n = 1;

      for (int cyc = 0; cyc < 3000; cyc++) begin
         in_valid     = ($urandom_range(0, 3) != 0);
         in_wr_en     = $urandom_range(0, 1);
         in_flag_we   = $urandom_range(0, 1);
         in_br_en     = $urandom_range(0, 1);
         in_br_cond   = 3'($urandom_range(0, 7));
         in_result    = 16'($urandom);
         in_status    = 16'($urandom);
         in_rd        = 3'($urandom_range(0, 7));
         in_br_target = 16'($urandom);
         out_ready    = ($urandom_range(0, 2) != 0);
         rst_n        = ($urandom_range(0, 199) != 0);
         tick();
      end
      idle();
      rst_n = 1;
      tick();
      tick();
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
